mem_arbiter: RTL

- Arbitrates the single shared multicycle main memory between I-cache miss fills, D-cache miss fills and D-cache write-through stores (SW).
- Sits between both caches' miss handlers and the main memory model.
- Sequences each 16-byte block fill as 8 pipelined word reads.
- Steers returned words to the owning cache with the word index.

---
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Shared main-memory arbiter: serves D-cache stores, D-cache block fills and
// I-cache block fills (fixed priority) with pipelined word reads.
module mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_miss,
  input  logic [ADDR_W-1:0]              i_miss_addr,
  input  logic                           d_miss,
  input  logic [ADDR_W-1:0]              d_miss_addr,
  input  logic                           d_wr_req,
  input  logic [ADDR_W-1:0]              d_wr_addr,
  input  logic [DATA_W-1:0]              d_wr_data,
  output logic                           mem_en,
  output logic                           mem_wr,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic [DATA_W-1:0]              mem_rdata,
  input  logic                           mem_data_valid,
  output logic [DATA_W-1:0]              fill_data,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
  output logic                           i_fill_we,
  output logic                           d_fill_we,
  output logic                           i_fill_done,
  output logic                           d_fill_done,
  output logic                           d_wr_ack,
  output logic                           busy
);

  localparam int WI_W = $clog2(BLOCK_WORDS);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WRITE  = 2'd1;
  localparam logic [1:0] ST_FILL_D = 2'd2;
  localparam logic [1:0] ST_FILL_I = 2'd3;

  localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'(2 * BLOCK_WORDS - 1);
  localparam logic [ADDR_W-1:0] WORD_MASK  = ~ADDR_W'(1);
  localparam logic [WI_W:0]     ISSUE_INC  = {{WI_W{1'b0}}, 1'b1};
  localparam logic [WI_W-1:0]   RECV_INC   = {{(WI_W-1){1'b0}}, 1'b1};
  localparam logic [WI_W-1:0]   RECV_LAST  = WI_W'(BLOCK_WORDS - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [WI_W:0]     issue_cnt_q, issue_cnt_d;
  logic [WI_W-1:0]   recv_cnt_q, recv_cnt_d;
  logic              in_fill_s, issuing_s, rx_s, last_rx_s;

  // issue_cnt MSB marks all words issued; fill addresses OR the word offset
  // into a block-aligned base so they can never carry out of the block.
  assign in_fill_s = (state_q == ST_FILL_D) || (state_q == ST_FILL_I);
  assign issuing_s = in_fill_s && !issue_cnt_q[WI_W];
  assign rx_s      = in_fill_s && mem_data_valid;
  assign last_rx_s = rx_s && (recv_cnt_q == RECV_LAST);

  // Next-state: grant in IDLE, count issues and returns during fills.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    case (state_q)
      ST_IDLE: begin
        issue_cnt_d = '0;
        recv_cnt_d  = '0;
        if (d_wr_req) begin
          state_d = ST_WRITE;
          addr_d  = d_wr_addr;
          wdata_d = d_wr_data;
        end else if (d_miss) begin
          state_d = ST_FILL_D;
          addr_d  = d_miss_addr & BLOCK_MASK;
        end else if (i_miss) begin
          state_d = ST_FILL_I;
          addr_d  = i_miss_addr & BLOCK_MASK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
      end
      ST_FILL_D, ST_FILL_I: begin
        if (issuing_s) begin
          issue_cnt_d = issue_cnt_q + ISSUE_INC;
        end else begin
          issue_cnt_d = issue_cnt_q;
        end
        if (rx_s) begin
          recv_cnt_d = recv_cnt_q + RECV_INC;
        end else begin
          recv_cnt_d = recv_cnt_q;
        end
        if (last_rx_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
    end
  end

  // Outputs decode from state; fill strobes follow mem_data_valid directly.
  always_comb begin
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    d_wr_ack    = 1'b0;
    if (state_q == ST_WRITE) begin
      mem_en    = 1'b1;
      mem_wr    = 1'b1;
      mem_addr  = addr_q & WORD_MASK;
      mem_wdata = wdata_q;
      d_wr_ack  = 1'b1;
    end else if (issuing_s) begin
      mem_en    = 1'b1;
      mem_addr  = addr_q | ADDR_W'({issue_cnt_q[WI_W-1:0], 1'b0});
    end else begin
      mem_en    = 1'b0;
    end
    fill_data   = rx_s ? mem_rdata : '0;
    fill_word   = rx_s ? recv_cnt_q : '0;
    i_fill_we   = rx_s && (state_q == ST_FILL_I);
    d_fill_we   = rx_s && (state_q == ST_FILL_D);
    i_fill_done = last_rx_s && (state_q == ST_FILL_I);
    d_fill_done = last_rx_s && (state_q == ST_FILL_D);
    busy        = (state_q != ST_IDLE);
  end

endmodule
